// File: rtl/input_port_if.sv
// Input-port handshake bundle: control-unit request, raw board inputs, captured word and status.
interface input_port_if #(
  parameter int DATA_W = 16
);
  logic              in_req;
  logic [DATA_W-1:0] switches;
  logic              key_n;
  logic [31:0]       in_data;
  logic              in_valid;
  logic              stall;
  logic              waiting;

  modport master (
    output in_req, switches, key_n,
    input  in_data, in_valid, stall, waiting
  );

  modport slave (
    input  in_req, switches, key_n,
    output in_data, in_valid, stall, waiting
  );
endinterface

// File: rtl/input_port.sv
// Stalls the core on an input instruction until a key press, then delivers the synchronized switches for one cycle.
// Capture lands 3+DEBOUNCE_CYCLES edges after the press with INPUT_PORT_DEBOUNCE_EN defined, 3 edges otherwise.
module input_port #(
  parameter int DATA_W          = 16,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input logic         clock,
  input logic         reset,
  input_port_if.slave io
);

  if (DATA_W < 1 || DATA_W > 32 || DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
    $error("input_port: DATA_W must be 1..32 and DEBOUNCE_CYCLES >= 1");
  end

  typedef enum logic [1:0] {IDLE, ARM, WAIT_PRESS, DELIVER} state_t;

  state_t            state;
  logic              key_m, key_s, db;
  logic [DATA_W-1:0] sw_m, sw_s;
  logic [31:0]       in_data_q;
  logic              in_valid_q;
  logic              waiting_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      key_m <= 1'b1;
      key_s <= 1'b1;
      sw_m  <= '0;
      sw_s  <= '0;
    end else begin
      key_m <= io.key_n;
      key_s <= key_m;
      sw_m  <= io.switches;
      sw_s  <= sw_m;
    end
  end

`ifdef INPUT_PORT_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CW-1:0] cnt;

  // Any sample agreeing with the current level restarts the stability count.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      db  <= 1'b1;
      cnt <= '0;
    end else if (key_s != db) begin
      if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        db  <= ~db;
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end else begin
      cnt <= '0;
    end
  end
`else
  assign db = key_s;
`endif

  // ARM absorbs a key already held when the request arrives, so a press is never reused.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      in_data_q  <= '0;
      in_valid_q <= 1'b0;
      waiting_q  <= 1'b0;
    end else begin
      in_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (io.in_req) begin
            state     <= db ? WAIT_PRESS : ARM;
            waiting_q <= 1'b1;
          end
        end
        ARM: begin
          if (!io.in_req) begin
            state     <= IDLE;
            waiting_q <= 1'b0;
          end else if (db) begin
            state <= WAIT_PRESS;
          end
        end
        WAIT_PRESS: begin
          if (!io.in_req) begin
            state     <= IDLE;
            waiting_q <= 1'b0;
          end else if (!db) begin
            in_data_q  <= 32'(sw_s);
            in_valid_q <= 1'b1;
            waiting_q  <= 1'b0;
            state      <= DELIVER;
          end
        end
        DELIVER: state <= IDLE;
        default: begin
          state     <= IDLE;
          waiting_q <= 1'b0;
        end
      endcase
    end
  end

  assign io.in_data  = in_data_q;
  assign io.in_valid = in_valid_q;
  assign io.waiting  = waiting_q;
  assign io.stall    = io.in_req & ~in_valid_q;

endmodule
